// File: rtl/lsu_store_queue.sv
// lsu_store_queue: speculative + committed store queues with a two-state memory drain FSM.
// Optional commit-time merging of same-doubleword stores is enabled by LSU_STQ_MERGE_EN.
module lsu_store_queue #(
  parameter int XLEN          = 64,
  parameter int PLEN          = 56,
  parameter int SPEC_DEPTH    = 4,
  parameter int COMMIT_DEPTH  = 8,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [PLEN-1:0]          paddr_i,
  input  logic [XLEN-1:0]          data_i,
  input  logic [XLEN/8-1:0]        be_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     ready_o,
  input  logic                     commit_i,
  output logic                     commit_ready_o,
  input  logic [11:0]              page_offset_i,
  output logic                     page_offset_matches_o,
  output logic                     no_st_pending_o,
  output logic                     empty_o,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  output logic [PLEN-1:0]          mem_addr_o,
  output logic [XLEN-1:0]          mem_data_o,
  output logic [XLEN/8-1:0]        mem_be_o
);
  localparam int SB = $clog2(SPEC_DEPTH);
  localparam int CB = $clog2(COMMIT_DEPTH);
  localparam int BW = XLEN / 8;
  typedef enum logic {IDLE, REQ} state_e;
  state_e          state_q;
  logic [PLEN-1:0] spec_addr_q [SPEC_DEPTH];
  logic [XLEN-1:0] spec_data_q [SPEC_DEPTH];
  logic [BW-1:0]   spec_be_q   [SPEC_DEPTH];
  logic [PLEN-1:0] cmt_addr_q  [COMMIT_DEPTH];
  logic [XLEN-1:0] cmt_data_q  [COMMIT_DEPTH];
  logic [BW-1:0]   cmt_be_q    [COMMIT_DEPTH];
  logic [SB-1:0]   spec_rd_q, spec_wr_q;
  logic [SB:0]     spec_cnt_q, spec_cnt_d;
  logic [CB-1:0]   cmt_rd_q, cmt_wr_q;
  logic [CB:0]     cmt_cnt_q, cmt_cnt_d;
  logic            do_push, do_commit, do_merge, do_alloc, do_pop;
  logic            unused_ok;
  assign unused_ok       = ^{trans_id_i, page_offset_i[2:0]};
  assign ready_o         = spec_cnt_q < (SB+1)'(SPEC_DEPTH);
  assign commit_ready_o  = cmt_cnt_q < (CB+1)'(COMMIT_DEPTH);
  assign no_st_pending_o = cmt_cnt_q == '0;
  assign empty_o         = spec_cnt_q == '0 && cmt_cnt_q == '0;
  assign mem_req_o       = state_q == REQ;
  assign mem_addr_o      = cmt_addr_q[cmt_rd_q];
  assign mem_data_o      = cmt_data_q[cmt_rd_q];
  assign mem_be_o        = cmt_be_q[cmt_rd_q];
  assign do_commit       = commit_i && commit_ready_o && spec_cnt_q != '0;
  assign do_push         = valid_i && ready_o && !flush_i;
  assign do_pop          = state_q == REQ && mem_gnt_i;
`ifdef LSU_STQ_MERGE_EN
  logic [CB-1:0] cmt_tail;
  assign cmt_tail = cmt_wr_q - CB'(1);
  // The head is frozen while presented to memory, so it must never absorb a merge.
  assign do_merge = do_commit && cmt_cnt_q != '0 && !(state_q == REQ && cmt_tail == cmt_rd_q) &&
                    cmt_addr_q[cmt_tail][PLEN-1:3] == spec_addr_q[spec_rd_q][PLEN-1:3];
`else
  assign do_merge = 1'b0;
`endif
  assign do_alloc   = do_commit && !do_merge;
  assign spec_cnt_d = flush_i ? '0 : spec_cnt_q + (SB+1)'(do_push) - (SB+1)'(do_commit);
  assign cmt_cnt_d  = cmt_cnt_q + (CB+1)'(do_alloc) - (CB+1)'(do_pop);
  always_comb begin
    page_offset_matches_o = 1'b0;
    for (int i = 0; i < SPEC_DEPTH; i++)
      if ({1'b0, SB'(SB'(i) - spec_rd_q)} < spec_cnt_q && spec_addr_q[i][11:3] == page_offset_i[11:3])
        page_offset_matches_o = 1'b1;
    for (int i = 0; i < COMMIT_DEPTH; i++)
      if ({1'b0, CB'(CB'(i) - cmt_rd_q)} < cmt_cnt_q && cmt_addr_q[i][11:3] == page_offset_i[11:3])
        page_offset_matches_o = 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_rd_q  <= '0;
      spec_wr_q  <= '0;
      spec_cnt_q <= '0;
      cmt_rd_q   <= '0;
      cmt_wr_q   <= '0;
      cmt_cnt_q  <= '0;
      state_q    <= IDLE;
    end else begin
      spec_cnt_q <= spec_cnt_d;
      cmt_cnt_q  <= cmt_cnt_d;
      spec_rd_q  <= spec_rd_q + SB'(do_commit);
      spec_wr_q  <= flush_i ? spec_rd_q + SB'(do_commit) : spec_wr_q + SB'(do_push);
      cmt_rd_q   <= cmt_rd_q + CB'(do_pop);
      cmt_wr_q   <= cmt_wr_q + CB'(do_alloc);
      state_q    <= ((state_q == REQ && !mem_gnt_i) || cmt_cnt_d != '0) ? REQ : IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      spec_addr_q[spec_wr_q] <= paddr_i;
      spec_data_q[spec_wr_q] <= data_i;
      spec_be_q[spec_wr_q]   <= be_i;
    end
    if (do_alloc) begin
      cmt_addr_q[cmt_wr_q] <= spec_addr_q[spec_rd_q];
      cmt_data_q[cmt_wr_q] <= spec_data_q[spec_rd_q];
      cmt_be_q[cmt_wr_q]   <= spec_be_q[spec_rd_q];
    end
`ifdef LSU_STQ_MERGE_EN
    if (do_merge) begin
      cmt_be_q[cmt_tail] <= cmt_be_q[cmt_tail] | spec_be_q[spec_rd_q];
      for (int b = 0; b < BW; b++)
        if (spec_be_q[spec_rd_q][b]) cmt_data_q[cmt_tail][8*b +: 8] <= spec_data_q[spec_rd_q][8*b +: 8];
    end
`endif
  end
endmodule

// File: tb/tb_lsu_store_queue.sv
// tb_lsu_store_queue: directed self-checking bench for lsu_store_queue.
module tb_lsu_store_queue;
  logic        clk = 1'b0;
  logic        rst_n, flush, valid, commit, gnt;
  logic [55:0] paddr;
  logic [63:0] data;
  logic [7:0]  be;
  logic [2:0]  tid;
  logic [11:0] po;
  logic        ready, commit_ready, pom, no_st, empty, req;
  logic [55:0] maddr;
  logic [63:0] mdata;
  logic [7:0]  mbe;
  int          n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  lsu_store_queue dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .paddr_i(paddr),
    .data_i(data), .be_i(be), .trans_id_i(tid), .ready_o(ready), .commit_i(commit),
    .commit_ready_o(commit_ready), .page_offset_i(po), .page_offset_matches_o(pom),
    .no_st_pending_o(no_st), .empty_o(empty), .mem_req_o(req), .mem_gnt_i(gnt),
    .mem_addr_o(maddr), .mem_data_o(mdata), .mem_be_o(mbe)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [55:0] a, input logic [63:0] d, input logic [7:0] b);
    valid = 1'b1; paddr = a; data = d; be = b;
    step;
    valid = 1'b0;
  endtask
  task automatic commit1;
    commit = 1'b1;
    step;
    commit = 1'b0;
  endtask
  task automatic probe(input string tag, input logic [11:0] off, input logic exp);
    po = off;
    #1;
    chk(tag, 64'(pom), 64'(exp));
  endtask
  initial begin
    rst_n = 1'b0; flush = 0; valid = 0; commit = 0; gnt = 0;
    paddr = '0; data = '0; be = '0; tid = '0; po = '0;
    step; step;
    rst_n = 1'b1;
    step;
    chk("rst_ready", 64'(ready), 1);
    chk("rst_commit_ready", 64'(commit_ready), 1);
    chk("rst_mem_req", 64'(req), 0);
    chk("rst_no_st", 64'(no_st), 1);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_pom", 64'(pom), 0);
    for (int i = 0; i < 4; i++) push(56'h100 + 56'(8 * i), 64'(i), 8'hFF);
    chk("full_ready", 64'(ready), 0);
    chk("full_empty", 64'(empty), 0);
    chk("full_mem_req", 64'(req), 0);
    push(56'h5000, 64'h55, 8'hFF);
    probe("full_ignored_push", 12'h000, 1'b0);
    probe("full_entry_visible", 12'h118, 1'b1);
    flush = 1'b1; step; flush = 1'b0;
    chk("flush_empty", 64'(empty), 1);
    chk("flush_ready", 64'(ready), 1);
    push(56'h1000, 64'h1111, 8'hFF);
    commit1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall_req_%0d", k), 64'(req), 1);
      chk($sformatf("stall_addr_%0d", k), 64'(maddr), 64'h1000);
      if (k < 3) step;
    end
    chk("stall_data", mdata, 64'h1111);
    chk("stall_be", 64'(mbe), 64'hFF);
    gnt = 1'b1; step; gnt = 1'b0;
    chk("grant_req", 64'(req), 0);
    chk("grant_no_st", 64'(no_st), 1);
    push(56'h2000, 64'hA0, 8'hFF);
    push(56'h2008, 64'hA1, 8'hFF);
    push(56'h2010, 64'hA2, 8'hFF);
    commit1;
    commit = 1'b1; flush = 1'b1; valid = 1'b1; paddr = 56'h2018;
    step;
    commit = 1'b0; flush = 1'b0; valid = 1'b0;
    chk("cf_ready", 64'(ready), 1);
    chk("cf_empty", 64'(empty), 0);
    chk("cf_no_st", 64'(no_st), 0);
    probe("cf_committed_kept", 12'h008, 1'b1);
    probe("cf_spec_dropped", 12'h010, 1'b0);
    probe("cf_push_dropped", 12'h018, 1'b0);
    gnt = 1'b1;
    chk("cf_drain0_addr", 64'(maddr), 64'h2000);
    step;
    chk("cf_drain1_req", 64'(req), 1);
    chk("cf_drain1_addr", 64'(maddr), 64'h2008);
    step;
    gnt = 1'b0;
    chk("cf_done_req", 64'(req), 0);
    chk("cf_done_empty", 64'(empty), 1);
    push(56'h2238, 64'h1, 8'h01);
    probe("po_match", 12'h23C, 1'b1);
    probe("po_nomatch", 12'h240, 1'b0);
    flush = 1'b1; step; flush = 1'b0;
    probe("po_after_flush", 12'h23C, 1'b0);
    push(56'h3000, 64'h33, 8'hFF);
    commit1;
    push(56'h4000, 64'h11223344_55667788, 8'h0F);
    push(56'h4000, 64'hAABBCCDD_EEFF0011, 8'hF0);
    commit1;
    commit1;
    gnt = 1'b1;
    chk("mg_head_addr", 64'(maddr), 64'h3000);
    step;
    chk("mg_e1_addr", 64'(maddr), 64'h4000);
`ifdef LSU_STQ_MERGE_EN
    chk("mg_e1_be", 64'(mbe), 64'hFF);
    chk("mg_e1_data", mdata, 64'hAABBCCDD_55667788);
    step;
`else
    chk("mg_e1_be", 64'(mbe), 64'h0F);
    chk("mg_e1_data", mdata, 64'h11223344_55667788);
    step;
    chk("mg_e2_addr", 64'(maddr), 64'h4000);
    chk("mg_e2_be", 64'(mbe), 64'hF0);
    step;
`endif
    gnt = 1'b0;
    chk("mg_done_req", 64'(req), 0);
    push(56'h6000, 64'h66, 8'hFF);
    commit1;
    chk("ar_req_before", 64'(req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req_dropped", 64'(req), 0);
    chk("ar_empty", 64'(empty), 1);
    chk("ar_no_st", 64'(no_st), 1);
    step;
    rst_n = 1'b1;
    step;
    chk("ar_after_req", 64'(req), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lsu_store_queue.md
LSU_STORE_QUEUE -- requirements
Module: lsu_store_queue

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width in bits.
REQ-002 SHALL have parameter PLEN, default 56, physical address width.
REQ-003 SHALL have parameter SPEC_DEPTH, default 4, speculative entries (power of two, >=2).
REQ-004 SHALL have parameter COMMIT_DEPTH, default 8, committed entries (power of two, >=2).
REQ-005 SHALL have parameter TRANS_ID_BITS, default 3, transaction-id width.
REQ-006 SHALL have port clk_i  input  1  clock; single clock, all state on rising edge.
REQ-007 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have ports flush_i in 1 (drop speculative stores); valid_i in 1 (store push); paddr_i in PLEN; data_i in XLEN; be_i in XLEN/8; trans_id_i in TRANS_ID_BITS.
REQ-009 SHALL have ports ready_o out 1 (speculative queue not full); commit_i in 1 (commit oldest speculative store); commit_ready_o out 1 (commit queue can accept).
REQ-010 SHALL have ports page_offset_i in 12; page_offset_matches_o out 1; no_st_pending_o out 1 (commit queue empty); empty_o out 1 (both queues empty).
REQ-011 SHALL have memory ports mem_req_o out 1; mem_gnt_i in 1; mem_addr_o out PLEN; mem_data_o out XLEN; mem_be_o out XLEN/8.

Function
REQ-012 Push SHALL occur when valid_i && ready_o; the entry is written at the speculative tail and is visible next cycle.
REQ-013 ready_o SHALL equal (speculative count < SPEC_DEPTH); valid_i while ready_o=0 SHALL be ignored.
REQ-014 commit_ready_o SHALL equal (commit count < COMMIT_DEPTH); commit_i moves the speculative head to the commit tail in one cycle, only when commit_ready_o=1 and speculative queue non-empty; otherwise commit_i is ignored.
REQ-015 Push and commit in the same cycle SHALL both take effect; a full speculative queue SHALL accept a push when a commit in the same cycle frees an entry only if ready_o was already 1 (no combinational ready_o from commit_i).
REQ-016 flush_i SHALL empty the speculative queue next cycle; commit_i in the same cycle SHALL be applied first (committed entry survives); valid_i in the same cycle SHALL be dropped.
REQ-017 Drain FSM SHALL have states IDLE and REQ: IDLE->REQ when commit queue non-empty; in REQ mem_req_o=1 with mem_addr_o/data_o/be_o from commit head held stable until mem_gnt_i; on mem_gnt_i pop head, go to REQ if entries remain, else IDLE.
REQ-018 Drain SHALL be independent of flush_i; committed stores are never dropped except by reset.
REQ-019 page_offset_matches_o SHALL be combinational: 1 when any valid entry in either queue has paddr[11:3] == page_offset_i[11:3].
REQ-020 Counts SHALL use pointers of clog2(DEPTH) bits with wrap-around and a separate count of clog2(DEPTH)+1 bits.
REQ-021 no_st_pending_o and empty_o SHALL reflect registered counts (no combinational path from inputs).

Reset
REQ-022 On rst_ni=0 all pointers and counts SHALL clear, FSM SHALL enter IDLE; ready_o=1, commit_ready_o=1, mem_req_o=0, no_st_pending_o=1, empty_o=1, page_offset_matches_o=0.
REQ-023 Reset asserted mid-transaction (mem_req_o=1) SHALL drop the request immediately, without waiting for mem_gnt_i.

Configuration
REQ-024 Macro LSU_STQ_MERGE_EN SHALL enable commit-time merging: if the commit tail is valid, is not the head while in REQ, and has equal paddr[PLEN-1:3], the committed store merges into it (be OR'd, data bytes replaced where new be=1), no new entry allocated.
REQ-025 Without LSU_STQ_MERGE_EN every commit SHALL allocate a new commit entry and no merge logic SHALL exist.

Verification
REQ-026 Reset, push 4 stores with ready throughout -> ready_o=0 after 4th, empty_o=0, mem_req_o=0.
REQ-027 Push A@0x1000, commit, mem_gnt_i held 0 for 3 cycles -> mem_req_o=1 with addr 0x1000 stable 4 cycles, pops on grant, no_st_pending_o=1 next cycle.
REQ-028 Push 3, commit 1, flush_i with commit_i same cycle -> 2 committed survive drain, speculative count 0.
REQ-029 Entry at paddr 0x2238, page_offset_i=0x23C -> page_offset_matches_o=1; 0x240 -> 0.
REQ-030 With LSU_STQ_MERGE_EN, commit be=0x0F then be=0xF0 same doubleword while gnt held off and a different head pending -> single entry be=0xFF; without macro -> two entries.
